// File: rtl/sysu_157_arbiter.sv
// ---------------------------------------------------------------------------
// sysu_157_arbiter
// Two-requester round-robin arbiter driving the S/G pins of a shared
// 74LS157-style quad 2:1 mux. Requester A owns the mux A inputs (S=0) and
// requester B owns the mux B inputs (S=1). G is an active-high disable.
// Before a new owner is granted, G is held high for GAP_CYC dead cycles
// (break-before-make). A per-grant time slice of HOLD_MAX cycles stops one
// side from locking out the other while both are requesting.
//
// Parameters:
//   HOLD_MAX  grant cycles allowed while the other side waits (1..255)
//   GAP_CYC   dead cycles with G=1 before a new grant (0..3)
//
// Ports:
//   CLK    rising-edge clock
//   CLR_N  asynchronous active-low reset
//   REQ_A  requester A wants the mux
//   REQ_B  requester B wants the mux
//   LOCK   (only with SYSU_ARB_LOCK_EN) owner may hold past its slice
//   GNT_A  A owns the mux
//   GNT_B  B owns the mux
//   S      mux select, 0 = A, 1 = B
//   G      mux disable, 1 forces mux outputs low
//   BUSY   arbiter is in any state other than IDLE
//
// Optional feature macro: SYSU_ARB_LOCK_EN (adds the LOCK input).
// ---------------------------------------------------------------------------
module sysu_157_arbiter #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic REQ_A,
    input  logic REQ_B,
`ifdef SYSU_ARB_LOCK_EN
    input  logic LOCK,
`endif
    output logic GNT_A,
    output logic GNT_B,
    output logic S,
    output logic G,
    output logic BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_OWN_A = 2'd2,
        ST_OWN_B = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_MAX_C = HOLD_MAX[7:0];
    localparam logic [1:0] GAP_LAST_C = GAP_CYC[1:0] - 2'd1;
    localparam logic       HAS_GAP_C  = (GAP_CYC != 0) ? 1'b1 : 1'b0;

    state_t     state_r;
    logic [7:0] hold_cnt_r;
    logic [1:0] gap_cnt_r;
    logic       last_b_r;
    logic       gnt_a_r;
    logic       gnt_b_r;
    logic       s_r;
    logic       g_r;
    logic       busy_r;

    logic       own_b_s;
    logic       owner_req_s;
    logic       other_req_s;
    logic       sel_req_s;
    logic       sel_other_s;
    logic [7:0] hold_inc_s;
    logic       lock_s;
    logic       handoff_s;
    logic       start_s;
    logic       start_b_s;
    logic       to_own_s;
    logic       to_idle_s;

    // Request views relative to the current owner / selected side.
    always_comb begin
        own_b_s     = (state_r == ST_OWN_B);
        owner_req_s = own_b_s ? REQ_B : REQ_A;
        other_req_s = own_b_s ? REQ_A : REQ_B;
        // During GAP the select register already names the chosen side.
        sel_req_s   = s_r ? REQ_B : REQ_A;
        sel_other_s = s_r ? REQ_A : REQ_B;
    end

    // Slice accounting: the count including the current grant cycle, so a
    // contended owner is preempted after exactly HOLD_MAX GNT cycles.
    always_comb begin
        if (hold_cnt_r >= HOLD_MAX_C) begin
            hold_inc_s = HOLD_MAX_C;
        end else begin
            hold_inc_s = hold_cnt_r + 8'd1;
        end
`ifdef SYSU_ARB_LOCK_EN
        lock_s = LOCK & owner_req_s;
`else
        lock_s = 1'b0;
`endif
        // Release takes precedence; preemption only matters while owner requests.
        handoff_s = ~owner_req_s |
                    (other_req_s & (hold_inc_s == HOLD_MAX_C) & ~lock_s);
    end

    // Transition decision: start a new selection, finish a gap, or go idle.
    always_comb begin
        start_s   = 1'b0;
        start_b_s = 1'b0;
        to_own_s  = 1'b0;
        to_idle_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (REQ_A || REQ_B) begin
                    start_s   = 1'b1;
                    // On a tie serve the side opposite the last one served.
                    start_b_s = (REQ_A && REQ_B) ? ~last_b_r : REQ_B;
                end else begin
                    start_s   = 1'b0;
                end
            end
            ST_GAP: begin
                if (!sel_req_s) begin
                    if (sel_other_s) begin
                        start_s   = 1'b1;
                        start_b_s = ~s_r;
                    end else begin
                        to_idle_s = 1'b1;
                    end
                end else if (gap_cnt_r == GAP_LAST_C) begin
                    to_own_s = 1'b1;
                end else begin
                    to_own_s = 1'b0;
                end
            end
            ST_OWN_A, ST_OWN_B: begin
                if (handoff_s) begin
                    if (other_req_s) begin
                        start_s   = 1'b1;
                        start_b_s = ~own_b_s;
                    end else begin
                        to_idle_s = 1'b1;
                    end
                end else begin
                    to_idle_s = 1'b0;
                end
            end
            default: begin
                to_idle_s = 1'b1;
            end
        endcase
    end

    // Arbiter FSM with registered mux controls and grants.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 8'd0;
            gap_cnt_r  <= 2'd0;
            last_b_r   <= 1'b1;
            gnt_a_r    <= 1'b0;
            gnt_b_r    <= 1'b0;
            s_r        <= 1'b0;
            g_r        <= 1'b1;
            busy_r     <= 1'b0;
        end else if (start_s) begin
            s_r     <= start_b_s;
            busy_r  <= 1'b1;
            if (HAS_GAP_C) begin
                state_r   <= ST_GAP;
                gap_cnt_r <= 2'd0;
                gnt_a_r   <= 1'b0;
                gnt_b_r   <= 1'b0;
                g_r       <= 1'b1;
            end else begin
                state_r    <= start_b_s ? ST_OWN_B : ST_OWN_A;
                hold_cnt_r <= 8'd0;
                last_b_r   <= start_b_s;
                gnt_a_r    <= ~start_b_s;
                gnt_b_r    <= start_b_s;
                g_r        <= 1'b0;
            end
        end else if (to_own_s) begin
            state_r    <= s_r ? ST_OWN_B : ST_OWN_A;
            hold_cnt_r <= 8'd0;
            last_b_r   <= s_r;
            gnt_a_r    <= ~s_r;
            gnt_b_r    <= s_r;
            g_r        <= 1'b0;
            busy_r     <= 1'b1;
        end else if (to_idle_s) begin
            // S keeps its last value while idle.
            state_r <= ST_IDLE;
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            g_r     <= 1'b1;
            busy_r  <= 1'b0;
        end else if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r + 2'd1;
        end else if ((state_r == ST_OWN_A) || (state_r == ST_OWN_B)) begin
            hold_cnt_r <= hold_inc_s;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign GNT_A = gnt_a_r;
    assign GNT_B = gnt_b_r;
    assign S     = s_r;
    assign G     = g_r;
    assign BUSY  = busy_r;

endmodule

// File: tb/tb_sysu_157_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for sysu_157_arbiter. Two instances share the request
// inputs: u_def (HOLD_MAX=4, GAP_CYC=1) and u_g0 (HOLD_MAX=3, GAP_CYC=0).
// A behavioural reference model (phase / remaining-gap / grant-length view)
// predicts the output vector {GNT_A, GNT_B, S, G, BUSY} for each instance.
// ---------------------------------------------------------------------------
module tb_sysu_157_arbiter;

    localparam int PH_IDLE = 0;
    localparam int PH_GAP  = 1;
    localparam int PH_OWN  = 2;

    logic CLK;
    logic CLR_N;
    logic REQ_A;
    logic REQ_B;
    logic LOCK;
    logic gnt_a0, gnt_b0, s0, g0, busy0;
    logic gnt_a1, gnt_b1, s1, g1, busy1;
    logic [4:0] obs0;
    logic [4:0] obs1;

    int tests;
    int fails;

    // Reference model state, index 0 = u_def, 1 = u_g0.
    int m_phase[2];
    int m_side[2];
    int m_gap_left[2];
    int m_granted[2];
    int m_last[2];
    int m_s[2];
    int m_hold[2];
    int m_gap[2];

    assign obs0 = {gnt_a0, gnt_b0, s0, g0, busy0};
    assign obs1 = {gnt_a1, gnt_b1, s1, g1, busy1};

    sysu_157_arbiter #(.HOLD_MAX(4), .GAP_CYC(1)) u_def (
        .CLK(CLK), .CLR_N(CLR_N), .REQ_A(REQ_A), .REQ_B(REQ_B),
`ifdef SYSU_ARB_LOCK_EN
        .LOCK(LOCK),
`endif
        .GNT_A(gnt_a0), .GNT_B(gnt_b0), .S(s0), .G(g0), .BUSY(busy0)
    );

    sysu_157_arbiter #(.HOLD_MAX(3), .GAP_CYC(0)) u_g0 (
        .CLK(CLK), .CLR_N(CLR_N), .REQ_A(REQ_A), .REQ_B(REQ_B),
`ifdef SYSU_ARB_LOCK_EN
        .LOCK(LOCK),
`endif
        .GNT_A(gnt_a1), .GNT_B(gnt_b1), .S(s1), .G(g1), .BUSY(busy1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic void model_reset(int i);
        m_phase[i]    = PH_IDLE;
        m_side[i]     = 0;
        m_gap_left[i] = 0;
        m_granted[i]  = 0;
        m_last[i]     = 1;
        m_s[i]        = 0;
    endfunction

    function automatic void model_grant(int i, int x);
        m_phase[i]   = PH_OWN;
        m_side[i]    = x;
        m_granted[i] = 0;
        m_last[i]    = x;
    endfunction

    function automatic void model_start(int i, int x);
        m_s[i]    = x;
        m_side[i] = x;
        if (m_gap[i] > 0) begin
            m_phase[i]    = PH_GAP;
            m_gap_left[i] = m_gap[i];
        end else begin
            model_grant(i, x);
        end
    endfunction

    // One rising edge of the model with the requests sampled at that edge.
    function automatic void model_step(int i, bit ra, bit rb, bit lk);
        bit rq[2];
        int own;
        int oth;
        rq[0] = ra;
        rq[1] = rb;
        own = m_side[i];
        oth = 1 - m_side[i];
        case (m_phase[i])
            PH_IDLE: begin
                if (ra && rb) model_start(i, 1 - m_last[i]);
                else if (ra) model_start(i, 0);
                else if (rb) model_start(i, 1);
            end
            PH_GAP: begin
                if (!rq[own]) begin
                    if (rq[oth]) model_start(i, oth);
                    else m_phase[i] = PH_IDLE;
                end else begin
                    m_gap_left[i] = m_gap_left[i] - 1;
                    if (m_gap_left[i] == 0) model_grant(i, own);
                end
            end
            default: begin
                m_granted[i] = m_granted[i] + 1;
                if (!rq[own] || (rq[oth] && m_granted[i] >= m_hold[i] && !lk)) begin
                    if (rq[oth]) model_start(i, oth);
                    else m_phase[i] = PH_IDLE;
                end
            end
        endcase
    endfunction

    function automatic logic [4:0] model_out(int i);
        logic ga, gb, g, b;
        ga = (m_phase[i] == PH_OWN) && (m_side[i] == 0);
        gb = (m_phase[i] == PH_OWN) && (m_side[i] == 1);
        g  = (m_phase[i] != PH_OWN);
        b  = (m_phase[i] != PH_IDLE);
        return {ga, gb, m_s[i][0], g, b};
    endfunction

    // Drive requests just after a falling edge, advance the model across the
    // next rising edge, and return at the following falling edge.
    task automatic cycle(input bit ra, input bit rb);
        REQ_A = ra;
        REQ_B = rb;
        for (int i = 0; i < 2; i++) begin
            if (CLR_N) model_step(i, ra, rb, LOCK);
            else model_reset(i);
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        CLR_N = 1'b0;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        LOCK  = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge CLK);
        @(negedge CLK);
        CLR_N = 1'b1;
    endtask

    task automatic test_reset();
        CLR_N = 1'b0;
        REQ_A = 1'b1;
        REQ_B = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            tests++;
            if (obs0 !== 5'b00010) begin
                fails++;
                $display("FAIL reset_def k=%0d: got %b want 00010", k, obs0);
            end
            tests++;
            if (obs1 !== 5'b00010) begin
                fails++;
                $display("FAIL reset_g0 k=%0d: got %b want 00010", k, obs1);
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [4:0] want0 [6];
        want0[0] = 5'b00011;
        want0[1] = 5'b10001;
        want0[2] = 5'b10001;
        want0[3] = 5'b10001;
        want0[4] = 5'b10001;
        want0[5] = 5'b00010;
        do_reset();
        for (int e = 0; e < 6; e++) begin
            cycle(e < 5, 1'b0);
            tests++;
            if (obs0 !== want0[e]) begin
                fails++;
                $display("FAIL single_def edge%0d: got %b want %b", e + 1, obs0, want0[e]);
            end
            tests++;
            if (obs1 !== model_out(1)) begin
                fails++;
                $display("FAIL single_g0 edge%0d: got %b want %b", e + 1, obs1, model_out(1));
            end
        end
    endtask

    task automatic test_contention();
        int a_cnt;
        do_reset();
        a_cnt = 0;
        for (int e = 1; e <= 16; e++) begin
            cycle(1'b1, 1'b1);
            if (e <= 5 && gnt_a0) a_cnt++;
            tests++;
            if (obs0 !== model_out(0)) begin
                fails++;
                $display("FAIL contend_def edge%0d: got %b want %b", e, obs0, model_out(0));
            end
            tests++;
            if (obs1 !== model_out(1)) begin
                fails++;
                $display("FAIL contend_g0 edge%0d: got %b want %b", e, obs1, model_out(1));
            end
            if (e == 6) begin
                tests++;
                if (obs0 !== 5'b00111) begin
                    fails++;
                    $display("FAIL contend_gap edge6: got %b want 00111", obs0);
                end
            end
            if (e == 7) begin
                tests++;
                if (obs0 !== 5'b01101) begin
                    fails++;
                    $display("FAIL contend_b edge7: got %b want 01101", obs0);
                end
            end
        end
        tests++;
        if (a_cnt != 4) begin
            fails++;
            $display("FAIL contend_a_slice: got %0d want 4", a_cnt);
        end
    endtask

    task automatic test_gap0();
        do_reset();
        cycle(1'b0, 1'b1);
        tests++;
        if (obs1 !== 5'b01101) begin
            fails++;
            $display("FAIL gap0_b_grant: got %b want 01101", obs1);
        end
        cycle(1'b0, 1'b0);
        tests++;
        if (obs1 !== 5'b00110) begin
            fails++;
            $display("FAIL gap0_release: got %b want 00110", obs1);
        end
        cycle(1'b1, 1'b0);
        tests++;
        if (obs1 !== 5'b10001) begin
            fails++;
            $display("FAIL gap0_a_grant: got %b want 10001", obs1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 0; e < 3; e++) cycle(1'b0, 1'b1);
        tests++;
        if (gnt_b0 !== 1'b1) begin
            fails++;
            $display("FAIL arst_pre_gnt_b: got %b want 1", gnt_b0);
        end
        #2;
        CLR_N = 1'b0;
        #1;
        tests++;
        if (obs0 !== 5'b00010) begin
            fails++;
            $display("FAIL arst_def_immediate: got %b want 00010", obs0);
        end
        tests++;
        if (obs1 !== 5'b00010) begin
            fails++;
            $display("FAIL arst_g0_immediate: got %b want 00010", obs1);
        end
        model_reset(0);
        model_reset(1);
        @(negedge CLK);
        CLR_N = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        tests++;
        if (gnt_a0 !== 1'b1 || gnt_b0 !== 1'b0) begin
            fails++;
            $display("FAIL arst_a_first: got gnt_a=%b gnt_b=%b want 1 0", gnt_a0, gnt_b0);
        end
        tests++;
        if (obs1 !== model_out(1)) begin
            fails++;
            $display("FAIL arst_g0_after: got %b want %b", obs1, model_out(1));
        end
    endtask

    task automatic test_random();
        bit ra, rb;
        logic prev_s0, prev_g0;
        do_reset();
        ra = 1'b0;
        rb = 1'b0;
        prev_s0 = s0;
        prev_g0 = g0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            cycle(ra, rb);
            tests++;
            if (obs0 !== model_out(0)) begin
                fails++;
                $display("FAIL rand_def n=%0d: got %b want %b", n, obs0, model_out(0));
            end
            tests++;
            if (obs1 !== model_out(1)) begin
                fails++;
                $display("FAIL rand_g0 n=%0d: got %b want %b", n, obs1, model_out(1));
            end
            tests++;
            if ((gnt_a0 && gnt_b0) || (gnt_a1 && gnt_b1)) begin
                fails++;
                $display("FAIL rand_dual_grant n=%0d: got def=%b%b g0=%b%b want no 11",
                         n, gnt_a0, gnt_b0, gnt_a1, gnt_b1);
            end
            tests++;
            if (!prev_g0 && !g0 && (prev_s0 !== s0)) begin
                fails++;
                $display("FAIL rand_s_while_g0 n=%0d: got S %b->%b want stable", n, prev_s0, s0);
            end
            prev_s0 = s0;
            prev_g0 = g0;
        end
    endtask

`ifdef SYSU_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        LOCK = 1'b1;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            cycle(1'b1, 1'b1);
            tests++;
            if (gnt_a0 !== 1'b1) begin
                fails++;
                $display("FAIL lock_hold n=%0d: got %b want 1", n, gnt_a0);
            end
        end
        LOCK = 1'b0;
        cycle(1'b1, 1'b1);
        tests++;
        if (gnt_a0 !== 1'b0 || g0 !== 1'b1) begin
            fails++;
            $display("FAIL lock_drop: got gnt_a=%b g=%b want 0 1", gnt_a0, g0);
        end
        cycle(1'b1, 1'b1);
        tests++;
        if (gnt_b0 !== 1'b1) begin
            fails++;
            $display("FAIL lock_b_grant: got %b want 1", gnt_b0);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        m_hold[0] = 4;
        m_gap[0]  = 1;
        m_hold[1] = 3;
        m_gap[1]  = 0;
        CLR_N = 1'b0;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        LOCK  = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge CLK);
        test_reset();
        test_single();
        test_contention();
        test_gap0();
        test_async_reset();
        test_random();
`ifdef SYSU_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
